// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-unit encodings, constants and address helpers.
package instr_fetch_pkg;

    localparam int          IW           = 32;
    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with +4 incrementer and redirect mux.
// With BRANCH_DELAY_SLOT_EN a pending redirect target (pend_pc) is held until the next fetch.
module fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        load,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] fetch_pc
);

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend;
    logic [31:0] pend_pc;

    assign fetch_pc = redirect_valid ? word_align(redirect_pc) : pend ? pend_pc : pc;

    // A newer redirect overwrites the pending target; starting a fetch consumes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (load) begin
            pend    <= 1'b0;
        end else if (redirect_valid) begin
            pend    <= 1'b1;
            pend_pc <= word_align(redirect_pc);
        end
    end
`else
    assign fetch_pc = redirect_valid ? word_align(redirect_pc) : pc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else if (load)
            pc <= fetch_pc;
        else if (inc)
            pc <= pc + 32'd4;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM feeding one instruction at a time to the decoder.
// Optional BRANCH_DELAY_SLOT_EN: redirects defer to after the in-flight/held word instead of squashing it.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    input  logic          stall,
    output logic [31:0]   pc_out,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          fetch_err
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t        state, state_n;
    logic          req_n, valid_n, drop, drop_n, err_n;
    logic [31:0]   addr_n, pcout_n, pc, fetch_pc;
    logic [IW-1:0] instr_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic          pc_inc, pc_load, squash;

`ifdef BRANCH_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = redirect_valid;
`endif

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk            (clk),
        .reset          (reset),
        .inc            (pc_inc),
        .load           (pc_load),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .fetch_pc       (fetch_pc)
    );

    always_comb begin
        state_n = state;
        req_n   = imem_req;
        addr_n  = imem_addr;
        instr_n = instr_out;
        valid_n = instr_valid;
        pcout_n = pc_out;
        drop_n  = drop;
        wait_n  = wait_cnt;
        err_n   = fetch_err;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        case (state)
            S_RESET: begin
                state_n = S_REQ;
                req_n   = 1'b1;
                addr_n  = pc;
            end
            S_REQ: begin
                if (imem_ack) begin
                    wait_n = '0;
                    // A stale word (redirect seen earlier or now) is thrown away and the target requested.
                    if (drop || squash) begin
                        pc_load = 1'b1;
                        addr_n  = fetch_pc;
                        drop_n  = 1'b0;
                    end else begin
                        instr_n = imem_rdata;
                        pcout_n = pc;
                        valid_n = 1'b1;
                        pc_inc  = 1'b1;
                        req_n   = 1'b0;
                        state_n = S_HOLD;
                    end
                end else begin
                    wait_n = wait_cnt + 1'b1;
                    if (squash) begin
                        pc_load = 1'b1;
                        drop_n  = 1'b1;
                    end
                    if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                        state_n = S_ERR;
                        req_n   = 1'b0;
                        err_n   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!stall || squash) begin
                    valid_n = 1'b0;
                    state_n = S_REQ;
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    pc_load = 1'b1;
                end
            end
            default: begin
                req_n   = 1'b0;
                valid_n = 1'b0;
                err_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RESET;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            drop        <= 1'b0;
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instr_out   <= instr_n;
            instr_valid <= valid_n;
            pc_out      <= pcout_n;
            drop        <= drop_n;
            wait_cnt    <= wait_n;
            fetch_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plus randomized bench with a program-order scoreboard for instr_fetch.
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr_out, pc_out;
    logic        instr_valid, fetch_err;
    logic        stall = 1'b1, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int errors = 0, checks = 0, consumed = 0;
    int fixed_lat = 0, lat = 0;
    bit mute = 1'b0, busy = 1'b0, sb_on = 1'b0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .MAX_WAIT(255)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .pc_out         (pc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == RPC) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected program order from a start address: sequential words, 32-bit wrap.
    function automatic void load_stream(input logic [31:0] t);
        for (int i = 0; i < 256; i++) q.push_back((t & 32'hFFFF_FFFC) + 32'(4 * i));
    endfunction

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
`ifdef BRANCH_DELAY_SLOT_EN
        begin
            logic [31:0] f;
            f = (q.size() > 0) ? q[0] : 32'h0;
            q.delete();
            q.push_back(f);
        end
`else
        q.delete();
`endif
        load_stream(t);
    endtask

    // Memory stub: each request answered after lat extra cycles with a fixed function of the address.
    always @(negedge clk) begin
        if (imem_ack || !imem_req || reset) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end else if (!mute) begin
            if (!busy) begin
                busy = 1'b1;
                lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else
                lat--;
        end
    end

    // Monitor: pops the expected stream on every consumed instruction and checks protocol invariants.
    logic [31:0] p_addr = '0, p_pc = '0, p_instr = '0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_hold = 1'b0;
    always @(negedge clk) begin
        #2;
        if (sb_on) begin
            chk("addr_align", imem_addr & 32'h3, 32'h0);
            if (p_req && imem_req && !p_ack) chk("addr_stable", imem_addr, p_addr);
            if (p_hold && instr_valid) begin
                chk("hold_pc", pc_out, p_pc);
                chk("hold_instr", instr_out, p_instr);
            end
`ifdef BRANCH_DELAY_SLOT_EN
            if (instr_valid && !stall) begin
`else
            if (instr_valid && !stall && !redirect_valid) begin
`endif
                if (q.size() == 0)
                    chk("sb_empty", 32'h1, 32'h0);
                else begin
                    logic [31:0] e;
                    e = q.pop_front();
                    chk("sb_pc", pc_out, e);
                    chk("sb_instr", instr_out, mem_word(e));
                    consumed++;
                end
            end
        end
        p_req   = imem_req;
        p_ack   = imem_ack;
        p_addr  = imem_addr;
        p_pc    = pc_out;
        p_instr = instr_out;
`ifdef BRANCH_DELAY_SLOT_EN
        p_hold  = instr_valid && stall;
`else
        p_hold  = instr_valid && stall && !redirect_valid;
`endif
    end

    task automatic tick();
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic next_valid(input string n, input logic [31:0] epc);
        int k;
        k = 0;
        while (!instr_valid && k < 50) begin
            tick();
            k++;
        end
        chk({n, "_valid"}, 32'(instr_valid), 32'h1);
        chk({n, "_pc"}, pc_out, epc);
        chk({n, "_instr"}, instr_out, mem_word(epc));
    endtask

    task automatic consume();
        stall = 1'b0;
        tick();
        stall = 1'b1;
    endtask

    task automatic consume_redirect(input logic [31:0] t);
        stall = 1'b0;
        redirect(t);
        tick();
        stall = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, "_req"}, 32'(imem_req), 32'h0);
        chk({n, "_addr"}, imem_addr, 32'h0);
        chk({n, "_instr"}, instr_out, 32'h0);
        chk({n, "_valid"}, 32'(instr_valid), 32'h0);
        chk({n, "_pc"}, pc_out, 32'h0);
        chk({n, "_err"}, 32'(fetch_err), 32'h0);
    endtask

    initial begin
        int n, k;
        #1 reset = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("rst");

        // First fetch with single-cycle memory latency.
        reset = 1'b0;
        q.delete();
        load_stream(RPC);
        sb_on = 1'b1;
        fixed_lat = 0;
        tick();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, RPC);
        tick();
        next_valid("first", RPC);
        chk("first_req_drop", 32'(imem_req), 32'h0);

        // Stalled hold keeps the instruction and stays off the memory bus.
        repeat (5) begin
            tick();
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_pc", pc_out, RPC);
            chk("stall_instr", instr_out, 32'h2008_0005);
        end
        consume();
        chk("second_req", 32'(imem_req), 32'h1);
        chk("second_addr", imem_addr, 32'h0040_0004);
        tick();
        next_valid("second", 32'h0040_0004);

        // Redirect during a slow fetch drops the in-flight word.
        fixed_lat = 3;
        consume();
        chk("slow_addr", imem_addr, 32'h0040_0008);
        redirect(32'h0040_0100);
        tick();
        chk("slow_addr_hold", imem_addr, 32'h0040_0008);
        chk("slow_req_hold", 32'(imem_req), 32'h1);
`ifdef BRANCH_DELAY_SLOT_EN
        next_valid("slot", 32'h0040_0008);
        consume();
`endif
        next_valid("redir", 32'h0040_0100);

        // Redirect while holding a stalled instruction.
        fixed_lat = 0;
        consume_redirect(32'h0040_000C);
        next_valid("hold_c", 32'h0040_000C);
        redirect(32'h0040_0200);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        chk("ds_kept_valid", 32'(instr_valid), 32'h1);
        chk("ds_kept_pc", pc_out, 32'h0040_000C);
        consume();
`else
        chk("squash_valid", 32'(instr_valid), 32'h0);
`endif
        next_valid("tgt200", 32'h0040_0200);

        // Wrap and misaligned redirect targets.
        consume_redirect(32'hFFFF_FFFC);
        next_valid("top", 32'hFFFF_FFFC);
        consume();
        next_valid("wrap", 32'h0000_0000);
        consume_redirect(32'h0040_0013);
        next_valid("unalign", 32'h0040_0010);

        // Randomized traffic against the scoreboard.
        fixed_lat = -1;
        repeat (3000) begin
            tick();
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: redirect($urandom);
                    1: redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                    2: redirect(RPC + 32'($urandom_range(0, 255)));
                    default: redirect($urandom);
                endcase
            end
        end
        stall = 1'b0;
        repeat (10) tick();
        sb_on = 1'b0;
        chk("progress", 32'(consumed > 200), 32'h1);

        // Memory never answers: timeout after exactly MAX_WAIT request cycles.
        mute = 1'b1;
        stall = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        k = 0;
        while (!fetch_err && k < 400) begin
            tick();
            if (imem_req) n++;
            k++;
        end
        chk("timeout_cycles", 32'(n), 32'd255);
        chk("timeout_err", 32'(fetch_err), 32'h1);
        chk("timeout_req", 32'(imem_req), 32'h0);
        chk("timeout_valid", 32'(instr_valid), 32'h0);
        repeat (10) tick();
        chk("err_sticky", 32'(fetch_err), 32'h1);
        chk("err_req", 32'(imem_req), 32'h0);

        // Asynchronous reset in the middle of a request.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("pre_async_req", 32'(imem_req), 32'h1);
        #3 reset = 1'b1;
        #1 chk_reset_outputs("async");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
